// File: rtl/ucsbece154a_encoder_pkg.sv
// Shared kind enumeration, RV32I opcode/funct constants and legality helpers
// for the instruction encoder.
package ucsbece154a_encoder_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned KIND_W    = 4;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [KIND_W-1:0] {
        KIND_ADD  = 4'd0,
        KIND_SUB  = 4'd1,
        KIND_AND  = 4'd2,
        KIND_OR   = 4'd3,
        KIND_SLT  = 4'd4,
        KIND_ADDI = 4'd5,
        KIND_ANDI = 4'd6,
        KIND_ORI  = 4'd7,
        KIND_SLTI = 4'd8,
        KIND_LW   = 4'd9,
        KIND_SW   = 4'd10,
        KIND_BEQ  = 4'd11,
        KIND_JAL  = 4'd12,
        KIND_LUI  = 4'd13
    } kind_e;

    // Opcodes, matching the controller's decode constants
    localparam logic [6:0] OP_RTYPE    = 7'b0110011;
    localparam logic [6:0] OP_ITYPE    = 7'b0010011;
    localparam logic [6:0] OP_LW       = 7'b0000011;
    localparam logic [6:0] OP_SW       = 7'b0100011;
    localparam logic [6:0] OP_BEQ      = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB  = 3'b000;
    localparam logic [2:0] F3_SLT      = 3'b010;
    localparam logic [2:0] F3_OR       = 3'b110;
    localparam logic [2:0] F3_AND      = 3'b111;
    localparam logic [2:0] F3_LW_SW    = 3'b010;
    localparam logic [2:0] F3_BEQ      = 3'b000;

    localparam logic [6:0] F7_DEFAULT  = 7'b0000000;
    localparam logic [6:0] F7_SUB      = 7'b0100000;

    // One abstract instruction request
    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [XLEN-1:0]   imm;
    } enc_req_t;

    // True when imm survives truncation to a signed field of the given width
    function automatic logic imm_fits(input logic [XLEN-1:0] imm, input int unsigned bits);
        logic [XLEN-1:0] ext;
        ext = XLEN'($signed(imm << (XLEN - bits)) >>> (XLEN - bits));
        return ext == imm;
    endfunction

    function automatic logic [2:0] alu_funct3(input logic [KIND_W-1:0] kind);
        logic [2:0] f3;
        f3 = F3_ADD_SUB;
        case (kind)
            KIND_SLT, KIND_SLTI: f3 = F3_SLT;
            KIND_OR,  KIND_ORI:  f3 = F3_OR;
            KIND_AND, KIND_ANDI: f3 = F3_AND;
            default:             f3 = F3_ADD_SUB;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/ucsbece154a_instr_pack.sv
// Combinational packer: abstract request -> 32-bit RV32I word plus a legality flag.
module ucsbece154a_instr_pack
    import ucsbece154a_encoder_pkg::*;
(
    input  enc_req_t         req,
    output logic [XLEN-1:0]  word_c,
    output logic             legal_c
);

    logic [2:0] f3;

    assign f3 = alu_funct3(req.kind);

    always_comb begin
        word_c  = '0;
        legal_c = 1'b0;
        case (req.kind)
            KIND_ADD, KIND_SUB, KIND_AND, KIND_OR, KIND_SLT: begin
                legal_c = 1'b1;
                word_c  = {(req.kind == KIND_SUB) ? F7_SUB : F7_DEFAULT,
                           req.rs2, req.rs1, f3, req.rd, OP_RTYPE};
            end
            KIND_ADDI, KIND_ANDI, KIND_ORI, KIND_SLTI: begin
                legal_c = imm_fits(req.imm, 12);
                word_c  = {req.imm[11:0], req.rs1, f3, req.rd, OP_ITYPE};
            end
            KIND_LW: begin
                legal_c = imm_fits(req.imm, 12);
                word_c  = {req.imm[11:0], req.rs1, F3_LW_SW, req.rd, OP_LW};
            end
            KIND_SW: begin
                legal_c = imm_fits(req.imm, 12);
                word_c  = {req.imm[11:5], req.rs2, req.rs1, F3_LW_SW,
                           req.imm[4:0], OP_SW};
            end
            // Branch and jump offsets are halfword aligned; bit 0 is never encoded
            KIND_BEQ: begin
                legal_c = imm_fits(req.imm, 13) & ~req.imm[0];
                word_c  = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                           req.imm[4:1], req.imm[11], OP_BEQ};
            end
            KIND_JAL: begin
                legal_c = imm_fits(req.imm, 21) & ~req.imm[0];
                word_c  = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                           req.rd, OP_JAL};
            end
            KIND_LUI: begin
                legal_c = (req.imm[11:0] == 12'h000);
                word_c  = {req.imm[31:12], req.rd, OP_LUI};
            end
            default: begin
                word_c  = '0;
                legal_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ucsbece154a_instr_encoder.sv
// Request-to-RV32I encoder with a one-deep output stage, word addressing,
// capacity limit and rejected-request accounting.
module ucsbece154a_instr_encoder
    import ucsbece154a_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        full_o,
    output logic        err_o,
    output logic [7:0]  err_count_o
);

    localparam int unsigned CNT_W = $clog2(IMEM_WORDS + 1);

    enc_req_t               req;
    logic [XLEN-1:0]        pack_word;
    logic                   pack_legal;

    logic                   restart;
    logic                   last_slot;
    logic                   hs_req;
    logic                   hs_out;

    logic [CNT_W-1:0]       emit_cnt;
    logic [CNT_W-1:0]       emit_cnt_n;
    logic                   valid_n;
    logic [XLEN-1:0]        instr_n;
    logic [XLEN-1:0]        addr_n;
    logic                   full_n;
    logic                   err_n;
    logic [ERR_CNT_W-1:0]   err_cnt_n;

    assign req.kind = kind_i;
    assign req.rd   = rd_i;
    assign req.rs1  = rs1_i;
    assign req.rs2  = rs2_i;
    assign req.imm  = imm_i;

    ucsbece154a_instr_pack u_pack (
        .req     (req),
        .word_c  (pack_word),
        .legal_c (pack_legal)
    );

    assign restart = reset | clear_i;

    // The buffered word already claims the final slot, so admitting another
    // would push the emitted total past IMEM_WORDS.
    assign last_slot = instr_valid_o & (emit_cnt == CNT_W'(IMEM_WORDS - 1));

    assign req_ready_o = ~restart & ~full_o & ~last_slot &
                         (~instr_valid_o | instr_ready_i);
    assign hs_req      = req_valid_i & req_ready_o;
    assign hs_out      = instr_valid_o & instr_ready_i;

    // Next-state for output stage, counters and error accounting
    always_comb begin
        valid_n    = instr_valid_o;
        instr_n    = instr_o;
        addr_n     = instr_addr_o;
        emit_cnt_n = emit_cnt;
        full_n     = full_o;
        err_n      = err_o;
        err_cnt_n  = err_count_o;

        if (hs_out) begin
            valid_n    = 1'b0;
            emit_cnt_n = emit_cnt + CNT_W'(1);
            addr_n     = instr_addr_o + 32'd4;
            full_n     = (emit_cnt_n == CNT_W'(IMEM_WORDS));
        end

        if (hs_req) begin
            if (pack_legal) begin
                valid_n = 1'b1;
                instr_n = pack_word;
            end else begin
                err_n = 1'b1;
                if (err_count_o != {ERR_CNT_W{1'b1}}) begin
                    err_cnt_n = err_count_o + ERR_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_addr_o  <= BASE_ADDR;
            emit_cnt      <= '0;
            full_o        <= 1'b0;
            err_o         <= 1'b0;
            err_count_o   <= '0;
        end else begin
            instr_valid_o <= valid_n;
            instr_o       <= instr_n;
            instr_addr_o  <= addr_n;
            emit_cnt      <= emit_cnt_n;
            full_o        <= full_n;
            err_o         <= err_n;
            err_count_o   <= err_cnt_n;
        end
    end

endmodule
